// File: rtl/obi_rr_arb_mux.sv
// obi_rr_arb_mux -- shares one OBI subordinate among NumSbrPorts managers.
//
// Round-robin arbitration on the A channel. The index of every granted port
// is pushed into an in-order routing FIFO; its head steers each R-channel
// beat back to the manager that issued the request. Both channels are purely
// combinational through the block (zero cycles of latency).
//
// The obi_pkg package ahead of the module carries the configuration struct
// and the default request/response struct types used by this block.
//
// Ports:
//   clk_i            clock
//   rst_ni           synchronous active-low reset, sampled on rising clk_i
//   sbr_ports_req_i  requests from the upstream managers   [NumSbrPorts]
//   sbr_ports_rsp_o  responses to the upstream managers    [NumSbrPorts]
//   mgr_port_req_o   request toward the shared subordinate
//   mgr_port_rsp_i   response from the shared subordinate
//   stall_cnt_o      (only with OBI_RR_ARB_STATS_EN) saturating 16-bit count
//                    of cycles with any request pending and no handshake
//
// Optional feature macro: OBI_RR_ARB_STATS_EN.

package obi_pkg;

   typedef struct packed {
      logic        UseRReady;
      int unsigned AddrWidth;
      int unsigned DataWidth;
      int unsigned IdWidth;
   } obi_cfg_t;

   localparam obi_cfg_t ObiDefaultConfig = '{
      UseRReady: 1'b0,
      AddrWidth: 32,
      DataWidth: 32,
      IdWidth:   4
   };

   // Widths below follow ObiDefaultConfig.
   typedef struct packed {
      logic [31:0] addr;
      logic        we;
      logic [3:0]  be;
      logic [31:0] wdata;
      logic [3:0]  aid;
      logic        a_optional;
   } obi_a_chan_t;

   typedef struct packed {
      obi_a_chan_t a;
      logic        req;
      logic        rready;
   } obi_req_t;

   typedef struct packed {
      logic [31:0] rdata;
      logic [3:0]  rid;
      logic        err;
      logic        r_optional;
   } obi_r_chan_t;

   typedef struct packed {
      obi_r_chan_t r;
      logic        gnt;
      logic        rvalid;
   } obi_rsp_t;

endpackage

module obi_rr_arb_mux #(
   parameter obi_pkg::obi_cfg_t ObiCfg      = obi_pkg::ObiDefaultConfig,
   parameter type               obi_req_t   = obi_pkg::obi_req_t,
   parameter type               obi_rsp_t   = obi_pkg::obi_rsp_t,
   parameter int unsigned       NumSbrPorts = 2,
   parameter int unsigned       NumMaxTrans = 2
) (
   input  logic     clk_i,
   input  logic     rst_ni,
   input  obi_req_t sbr_ports_req_i [NumSbrPorts],
   output obi_rsp_t sbr_ports_rsp_o [NumSbrPorts],
   output obi_req_t mgr_port_req_o,
   input  obi_rsp_t mgr_port_rsp_i
`ifdef OBI_RR_ARB_STATS_EN
   ,
   output logic [15:0] stall_cnt_o
`endif
);

   localparam int unsigned IdxW = $clog2(NumSbrPorts);
   localparam int unsigned PtrW = (NumMaxTrans > 1) ? $clog2(NumMaxTrans) : 1;
   localparam int unsigned CntW = $clog2(NumMaxTrans + 1);

   typedef logic [IdxW-1:0] idx_t;
   typedef logic [PtrW-1:0] ptr_t;

   idx_t            rr_q, rr_d;
   logic            lock_q, lock_d;
   idx_t            lock_idx_q, lock_idx_d;
   idx_t            fifo_q [NumMaxTrans];
   idx_t            fifo_d [NumMaxTrans];
   ptr_t            wr_ptr_q, wr_ptr_d;
   ptr_t            rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] cnt_q, cnt_d;

   idx_t cand_idx, sel_idx, head_idx;
   logic cand_found, sel_req, fifo_full, fifo_empty;
   logic mgr_req, hs, pop, head_rready;

   // First requesting port at or after the rr pointer, wrapping around.
   // NOTE: every variable written in a combinational block is given a default
   // before any conditional assignment, so no path can leave it holding its
   // old value and infer a latch.
   always_comb begin : cand_search
      int unsigned j;
      idx_t        j_idx;
      j          = 0;
      j_idx      = '0;
      cand_found = 1'b0;
      cand_idx   = rr_q;
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
         j = 32'(rr_q) + i;
         if (j >= NumSbrPorts) j = j - NumSbrPorts;
         j_idx = idx_t'(j);
         if (!cand_found && sbr_ports_req_i[j_idx].req) begin
            cand_found = 1'b1;
            cand_idx   = j_idx;
         end
      end
   end

   always_comb begin
      fifo_full   = (cnt_q == CntW'(NumMaxTrans));
      fifo_empty  = (cnt_q == '0);
      // A presented-but-ungranted request stays on the bus until accepted.
      sel_idx     = lock_q ? lock_idx_q : cand_idx;
      sel_req     = lock_q ? sbr_ports_req_i[lock_idx_q].req : cand_found;
      mgr_req     = rst_ni & sel_req & ~fifo_full;
      hs          = mgr_req & mgr_port_rsp_i.gnt;
      head_idx    = fifo_q[rd_ptr_q];
      head_rready = sbr_ports_req_i[head_idx].rready;
      pop         = rst_ni & mgr_port_rsp_i.rvalid & ~fifo_empty
                  & (~ObiCfg.UseRReady | head_rready);
   end

   always_comb begin
      mgr_port_req_o        = '0;
      mgr_port_req_o.a      = sbr_ports_req_i[sel_idx].a;
      mgr_port_req_o.req    = mgr_req;
      mgr_port_req_o.rready = ObiCfg.UseRReady ? (rst_ni & ~fifo_empty & head_rready)
                                               : 1'b1;
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
         sbr_ports_rsp_o[i]        = '0;
         sbr_ports_rsp_o[i].r      = mgr_port_rsp_i.r;
         sbr_ports_rsp_o[i].gnt    = hs & (sel_idx == idx_t'(i));
         // A response with nothing outstanding has no owner and is dropped.
         sbr_ports_rsp_o[i].rvalid = rst_ni & mgr_port_rsp_i.rvalid & ~fifo_empty
                                   & (head_idx == idx_t'(i));
      end
   end

   always_comb begin
      rr_d       = rr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      cnt_d      = cnt_q;
      if (hs) begin
         rr_d             = (sel_idx == idx_t'(NumSbrPorts - 1)) ? '0 : sel_idx + 1'b1;
         lock_d           = 1'b0;
         fifo_d[wr_ptr_q] = sel_idx;
         wr_ptr_d         = (wr_ptr_q == ptr_t'(NumMaxTrans - 1)) ? '0 : wr_ptr_q + 1'b1;
      end else if (mgr_req) begin
         lock_d     = 1'b1;
         lock_idx_d = sel_idx;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == ptr_t'(NumMaxTrans - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({hs, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before the edge, independent of block order.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         rr_q       <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
      end else begin
         rr_q       <= rr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         cnt_q      <= cnt_d;
      end
   end

   // NOTE: the routing storage is deliberately not reset; an entry is only
   // read while cnt_q says it holds a live index, so its reset value is moot.
   always_ff @(posedge clk_i) begin
      fifo_q <= fifo_d;
   end

`ifdef OBI_RR_ARB_STATS_EN
   logic [15:0] stall_cnt_q, stall_cnt_d;
   logic        any_req;

   always_comb begin
      any_req = 1'b0;
      for (int unsigned i = 0; i < NumSbrPorts; i++) begin
         any_req = any_req | sbr_ports_req_i[i].req;
      end
      stall_cnt_d = stall_cnt_q;
      if (any_req && !hs && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) stall_cnt_q <= '0;
      else         stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   // Statistics disabled: no stall counter is built.
`endif

endmodule

// File: tb/tb_obi_rr_arb_mux.sv
// Self-checking bench for obi_rr_arb_mux with three ports and a two-deep
// routing FIFO. A queue-based reference model checks every cycle; directed
// sequences add literal expectations for the main scenarios.
module tb_obi_rr_arb_mux;
   import obi_pkg::*;

   localparam int unsigned N = 3;
   localparam int unsigned D = 2;
   localparam obi_cfg_t CfgRr = '{UseRReady: 1'b1, AddrWidth: 32, DataWidth: 32, IdWidth: 4};
   localparam obi_cfg_t CfgNr = '{UseRReady: 1'b0, AddrWidth: 32, DataWidth: 32, IdWidth: 4};

   logic     clk_i  = 1'b0;
   logic     rst_ni = 1'b0;
   obi_req_t sbr_req    [N];
   obi_rsp_t sbr_rsp    [N];
   obi_rsp_t nr_sbr_rsp [N];
   obi_req_t mgr_req, nr_mgr_req;
   obi_rsp_t mgr_rsp;
`ifdef OBI_RR_ARB_STATS_EN
   logic [15:0] stall_cnt, nr_stall_cnt;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: outstanding owners in order, rr pointer, held port.
   int q[$];
   int m_rr   = 0;
   int m_lock = -1;

   always #5 clk_i = ~clk_i;

   obi_rr_arb_mux #(
      .ObiCfg(CfgRr), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
      .NumSbrPorts(N), .NumMaxTrans(D)
   ) u_dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .sbr_ports_req_i(sbr_req), .sbr_ports_rsp_o(sbr_rsp),
      .mgr_port_req_o(mgr_req), .mgr_port_rsp_i(mgr_rsp)
`ifdef OBI_RR_ARB_STATS_EN
      , .stall_cnt_o(stall_cnt)
`endif
   );

   obi_rr_arb_mux #(
      .ObiCfg(CfgNr), .obi_req_t(obi_req_t), .obi_rsp_t(obi_rsp_t),
      .NumSbrPorts(N), .NumMaxTrans(D)
   ) u_dut_nr (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .sbr_ports_req_i(sbr_req), .sbr_ports_rsp_o(nr_sbr_rsp),
      .mgr_port_req_o(nr_mgr_req), .mgr_port_rsp_i(mgr_rsp)
`ifdef OBI_RR_ARB_STATS_EN
      , .stall_cnt_o(nr_stall_cnt)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [N-1:0] gnt_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = sbr_rsp[i].gnt;
      return v;
   endfunction

   function automatic logic [N-1:0] rvalid_vec();
      logic [N-1:0] v;
      for (int i = 0; i < N; i++) v[i] = sbr_rsp[i].rvalid;
      return v;
   endfunction

   function automatic logic [N-1:0] onehot(input int p);
      logic [N-1:0] v;
      v    = '0;
      v[p] = 1'b1;
      return v;
   endfunction

   // One model step, evaluated mid-cycle while inputs are stable.
   task automatic model_step();
      int           sel;
      logic         sel_v, e_req, hs, pop, e_rready, bc_ok;
      logic [N-1:0] e_gnt, e_rv;
      check("nr_rready", 32'(nr_mgr_req.rready), 32'(1));
      if (!rst_ni) begin
         check("rst_mgr_req", 32'(mgr_req.req), 32'(0));
         check("rst_gnt", 32'(gnt_vec()), 32'(0));
         check("rst_rvalid", 32'(rvalid_vec()), 32'(0));
         q.delete();
         m_rr   = 0;
         m_lock = -1;
         return;
      end
      sel = -1;
      if (m_lock >= 0) sel = m_lock;
      else begin
         for (int k = 0; k < N; k++) begin
            int p;
            p = (m_rr + k) % N;
            if (sel < 0 && sbr_req[p].req) sel = p;
         end
      end
      sel_v    = (sel >= 0) ? sbr_req[sel].req : 1'b0;
      e_req    = sel_v && (q.size() < D);
      hs       = e_req && mgr_rsp.gnt;
      e_gnt    = '0;
      e_rv     = '0;
      e_rready = 1'b0;
      if (hs) e_gnt[sel] = 1'b1;
      if (q.size() > 0) begin
         if (mgr_rsp.rvalid) e_rv[q[0]] = 1'b1;
         e_rready = sbr_req[q[0]].rready;
      end
      check("mgr_req", 32'(mgr_req.req), 32'(e_req));
      check("gnt", 32'(gnt_vec()), 32'(e_gnt));
      check("rvalid", 32'(rvalid_vec()), 32'(e_rv));
      check("mgr_rready", 32'(mgr_req.rready), 32'(e_rready));
      if (e_req) begin
         check("mgr_addr", mgr_req.a.addr, sbr_req[sel].a.addr);
         check("mgr_a_whole", 32'(mgr_req.a == sbr_req[sel].a), 32'(1));
      end
      bc_ok = 1'b1;
      for (int i = 0; i < N; i++) if (sbr_rsp[i].r !== mgr_rsp.r) bc_ok = 1'b0;
      check("r_bcast", 32'(bc_ok), 32'(1));
      pop = mgr_rsp.rvalid && (q.size() > 0) && sbr_req[q[0]].rready;
      if (pop) void'(q.pop_front());
      if (hs) begin
         q.push_back(sel);
         m_rr   = (sel + 1) % N;
         m_lock = -1;
      end else if (e_req) begin
         m_lock = sel;
      end
   endtask

   initial begin : compare
      forever begin
         @(negedge clk_i);
         model_step();
      end
   end

   task automatic idle_inputs();
      for (int p = 0; p < N; p++) begin
         sbr_req[p]        = '0;
         sbr_req[p].rready = 1'b1;
      end
      mgr_rsp = '0;
   endtask

   task automatic set_req(input int p, input logic r, input logic [31:0] addr);
      sbr_req[p].req     = r;
      sbr_req[p].a.addr  = addr;
      sbr_req[p].a.aid   = 4'(p);
      sbr_req[p].a.wdata = addr ^ 32'h5A5A_0000;
      sbr_req[p].a.we    = addr[4];
      sbr_req[p].a.be    = 4'hF;
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   initial begin : stim
      idle_inputs();
      rst_ni = 1'b0;
      repeat (2) @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      @(negedge clk_i);
      check("reset_mgr_req", 32'(mgr_req.req), 32'(0));
      check("reset_gnt", 32'(gnt_vec()), 32'(0));
      check("reset_rvalid", 32'(rvalid_vec()), 32'(0));
      next_cycle();

      // All three ports request, target grants every cycle, rvalid one cycle later.
      for (int k = 0; k < 6; k++) begin
         for (int p = 0; p < N; p++) set_req(p, 1'b1, 32'h100 + 32'(p * 4));
         mgr_rsp.gnt     = 1'b1;
         mgr_rsp.rvalid  = (k > 0);
         mgr_rsp.r.rdata = 32'hA000 + 32'(k);
         mgr_rsp.r.rid   = 4'(k);
         @(negedge clk_i);
         check("rr_gnt_order", 32'(gnt_vec()), 32'(onehot(k % 3)));
         if (k > 0) check("rr_rvalid_order", 32'(rvalid_vec()), 32'(onehot((k - 1) % 3)));
         next_cycle();
      end
      idle_inputs();
      mgr_rsp.rvalid = 1'b1;
      @(negedge clk_i);
      check("rr_last_rvalid", 32'(rvalid_vec()), 32'(3'b100));
      next_cycle();
      idle_inputs();
      next_cycle();

      // Stalled grant: port 1 held at 0x40 even after port 0 starts requesting.
      for (int c = 1; c <= 5; c++) begin
         set_req(1, c <= 4, 32'h40);
         set_req(0, c >= 2, 32'h80);
         mgr_rsp.gnt = (c >= 4);
         @(negedge clk_i);
         check("lock_addr", mgr_req.a.addr, (c <= 4) ? 32'h40 : 32'h80);
         check("lock_gnt", 32'(gnt_vec()), (c < 4) ? 32'(0) : (c == 4) ? 32'(3'b010) : 32'(3'b001));
         next_cycle();
      end

      // FIFO full with owners 1,0; port 2 must wait and is not granted on the pop cycle.
      idle_inputs();
      set_req(2, 1'b1, 32'hC0);
      mgr_rsp.gnt = 1'b1;
      @(negedge clk_i);
      check("full_mgr_req", 32'(mgr_req.req), 32'(0));
      check("full_gnt", 32'(gnt_vec()), 32'(0));
      next_cycle();
      mgr_rsp.rvalid = 1'b1;
      @(negedge clk_i);
      check("full_pop_no_bypass", 32'(mgr_req.req), 32'(0));
      check("full_pop_rvalid", 32'(rvalid_vec()), 32'(3'b010));
      next_cycle();
      @(negedge clk_i);
      check("after_pop_gnt", 32'(gnt_vec()), 32'(3'b100));
      check("after_pop_rvalid", 32'(rvalid_vec()), 32'(3'b001));
      next_cycle();

      // Head is port 2, which withholds rready for four cycles.
      idle_inputs();
      sbr_req[2].rready = 1'b0;
      mgr_rsp.rvalid    = 1'b1;
      mgr_rsp.r.rdata   = 32'hBEEF_0002;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk_i);
         check("rready_hold_rvalid", 32'(rvalid_vec()), 32'(3'b100));
         check("rready_hold_mgr", 32'(mgr_req.rready), 32'(0));
         next_cycle();
      end
      sbr_req[2].rready = 1'b1;
      @(negedge clk_i);
      check("rready_pop_rvalid", 32'(rvalid_vec()), 32'(3'b100));
      check("rready_pop_mgr", 32'(mgr_req.rready), 32'(1));
      next_cycle();
      @(negedge clk_i);
      check("empty_drop_rvalid", 32'(rvalid_vec()), 32'(0));
      check("empty_mgr_rready", 32'(mgr_req.rready), 32'(0));
      next_cycle();

      // Two outstanding, then reset; FIFO and rr pointer must be cleared.
      idle_inputs();
      set_req(0, 1'b1, 32'h200);
      set_req(1, 1'b1, 32'h204);
      mgr_rsp.gnt = 1'b1;
      @(negedge clk_i);
      check("pre_rst_gnt0", 32'(gnt_vec()), 32'(3'b001));
      next_cycle();
      set_req(0, 1'b0, 32'h200);
      @(negedge clk_i);
      check("pre_rst_gnt1", 32'(gnt_vec()), 32'(3'b010));
      next_cycle();
      idle_inputs();
      rst_ni         = 1'b0;
      mgr_rsp.rvalid = 1'b1;
      set_req(2, 1'b1, 32'h300);
      mgr_rsp.gnt    = 1'b1;
      next_cycle();
      idle_inputs();
      rst_ni         = 1'b1;
      mgr_rsp.rvalid = 1'b1;
      @(negedge clk_i);
      check("post_rst_rvalid", 32'(rvalid_vec()), 32'(0));
      check("post_rst_gnt", 32'(gnt_vec()), 32'(0));
      next_cycle();
      idle_inputs();
      set_req(1, 1'b1, 32'h400);
      set_req(2, 1'b1, 32'h500);
      mgr_rsp.gnt = 1'b1;
      @(negedge clk_i);
      check("post_rst_rr_gnt", 32'(gnt_vec()), 32'(3'b010));
      next_cycle();
      idle_inputs();
      mgr_rsp.rvalid = 1'b1;
      @(negedge clk_i);
      check("post_rst_resp", 32'(rvalid_vec()), 32'(3'b010));
      next_cycle();
      idle_inputs();
      next_cycle();

`ifdef OBI_RR_ARB_STATS_EN
      rst_ni = 1'b0;
      next_cycle();
      rst_ni = 1'b1;
      for (int c = 0; c < 5; c++) begin
         set_req(0, 1'b1, 32'h600);
         mgr_rsp.gnt = (c >= 3);
         next_cycle();
      end
      idle_inputs();
      @(negedge clk_i);
      check("stall_cnt_3", 32'(stall_cnt), 32'(3));
      next_cycle();
      set_req(0, 1'b1, 32'h604);
      repeat (65540) next_cycle();
      @(negedge clk_i);
      check("stall_cnt_sat", 32'(stall_cnt), 32'hFFFF);
      next_cycle();
      @(negedge clk_i);
      check("stall_cnt_hold", 32'(stall_cnt), 32'hFFFF);
      idle_inputs();
      next_cycle();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
